core_bus_bridge: RTL and testbench

CORE_BUS_BRIDGE -- requirements
Module: core_bus_bridge

---
 rtl/bus_map_pkg.sv | 45 ++++
 rtl/core_bus_bridge_if.sv | 13 +
 rtl/uart_tx_unit.sv | 156 +++++++++++++++
 rtl/core_bus_bridge.sv | 105 ++++++++++
 tb/tb_core_bus_bridge.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_map_pkg.sv
// Shared address map for the core bus bridge.
// Holds the MMIO register addresses, the UART_STAT bit positions and a
// decode helper so the bridge, the testbench and firmware headers agree on
// one definition of the memory map.
package bus_map_pkg;

  localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;
  localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0004;
  localparam logic [31:0] TIMER_ADDR     = 32'h1000_0008;
  localparam logic [31:0] HALT_ADDR      = 32'h1000_000C;

  // UART_STAT layout: {28'b0, overflow, busy, empty, full}
  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;

  typedef enum logic [2:0] {
    REGION_RAM,
    REGION_UART_DATA,
    REGION_UART_STAT,
    REGION_TIMER,
    REGION_HALT,
    REGION_NONE
  } region_e;

  // RAM occupies [0, mem_bytes); the four MMIO registers are exact-match.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] mem_bytes);
    region_e r;
    if (addr < mem_bytes) begin
      r = REGION_RAM;
    end else begin
      case (addr)
        UART_DATA_ADDR: r = REGION_UART_DATA;
        UART_STAT_ADDR: r = REGION_UART_STAT;
        TIMER_ADDR:     r = REGION_TIMER;
        HALT_ADDR:      r = REGION_HALT;
        default:        r = REGION_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/core_bus_bridge_if.sv
// Core-side memory bus: byte address, write data, write enable and the
// zero-latency read data returned by the bridge.
//   master : the CPU core (drives address/data_out/we, reads data_in)
//   slave  : the bridge   (reads address/data_out/we, drives data_in)
interface core_bus_bridge_if;
  logic [31:0] address;
  logic [31:0] data_out;
  logic        we;
  logic [31:0] data_in;

  modport master (output address, output data_out, output we, input data_in);
  modport slave  (input address, input data_out, input we, output data_in);
endinterface

// File: rtl/uart_tx_unit.sv
// UART transmitter: FIFO_DEPTH-entry byte FIFO feeding an 8N1 serializer.
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   push, push_data   enqueue one byte per cycle; dropped when full unless
//                     the serializer pops in the same cycle
//   tx                serial line, idle high (registered)
//   full, empty       FIFO status
//   busy              serializer is not idle
//   overflow, clr_ovf sticky dropped-push flag and its clear
// FIFO_DEPTH must be a power of 2 and at least 2; CLKS_PER_BIT at least 2.
module uart_tx_unit #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       tx,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  input  logic       clr_ovf
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH    = (PW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          pop, push_ok;

  assign full     = (count_q == DEPTH);
  assign empty    = (count_q == '0);
  assign busy     = (state_q != ST_IDLE);
  assign overflow = ovf_q;
  assign tx       = tx_q;

  // Serializer: each of START, DATA (x8) and STOP holds for CLKS_PER_BIT cycles.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem_q[rd_ptr_q];
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the state being entered so tx is glitch-free.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping; a pop in the same cycle makes room for a push when full.
  always_comb begin
    push_ok  = push && (!full || pop);
    rd_ptr_d = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q + (PW + 1)'(push_ok) - (PW + 1)'(pop);
    if (clr_ovf)             ovf_d = 1'b0;
    else if (push && !push_ok) ovf_d = 1'b1;
    else                     ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers and count
  // define validity, and leaving storage unreset lets it map to RAM cells.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/core_bus_bridge.sv
// Core bus bridge: decodes the core's bus into a word RAM and four MMIO
// registers (UART data/status, free-running timer, halt).
// Ports:
//   clk, resetn  clock, synchronous active-low reset
//   bus          core bus (slave side); reads return in the same cycle
//   uart_tx      serial TX line, idle high
//   halt         sticky program-finished flag
//   exit_code    byte captured by the first HALT write
module core_bus_bridge
  import bus_map_pkg::*;
#(
  parameter int MEM_WORDS    = 4096,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic               clk,
  input  logic               resetn,
  core_bus_bridge_if.slave   bus,
  output logic               uart_tx,
  output logic               halt,
  output logic [7:0]         exit_code
);

  localparam int          IW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  logic [31:0] ram_q [MEM_WORDS];
  region_e     region;
  logic        wr;
  logic [IW-1:0] ram_idx;
  logic        uart_push, clr_ovf;
  logic        u_full, u_empty, u_busy, u_ovf;
  logic [31:0] stat;
  logic [31:0] timer_q, timer_d;
  logic        halt_q, halt_d;
  logic [7:0]  exit_code_q, exit_code_d;

  always_comb begin
    region    = decode_region(bus.address, MEM_BYTES);
    // Writes are suppressed entirely while reset is held.
    wr        = resetn && bus.we;
    ram_idx   = bus.address[IW+1:2];
    uart_push = wr && (region == REGION_UART_DATA);
    clr_ovf   = wr && (region == REGION_UART_STAT) && bus.data_out[STAT_OVF_BIT];

    timer_d = (wr && (region == REGION_TIMER)) ? bus.data_out : timer_q + 32'd1;

    halt_d      = halt_q;
    exit_code_d = exit_code_q;
    if (wr && (region == REGION_HALT) && !halt_q) begin
      halt_d      = 1'b1;
      exit_code_d = bus.data_out[7:0];
    end

    stat                 = '0;
    stat[STAT_FULL_BIT]  = u_full;
    stat[STAT_EMPTY_BIT] = u_empty;
    stat[STAT_BUSY_BIT]  = u_busy;
    stat[STAT_OVF_BIT]   = u_ovf;

    case (region)
      REGION_RAM:       bus.data_in = ram_q[ram_idx];
      REGION_UART_STAT: bus.data_in = stat;
      REGION_TIMER:     bus.data_in = timer_q;
      default:          bus.data_in = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      timer_q     <= '0;
      halt_q      <= 1'b0;
      exit_code_q <= '0;
    end else begin
      timer_q     <= timer_d;
      halt_q      <= halt_d;
      exit_code_q <= exit_code_d;
    end
  end

  // Full-word writes only; the core merges sub-word stores itself.
  always_ff @(posedge clk) begin
    if (wr && (region == REGION_RAM)) ram_q[ram_idx] <= bus.data_out;
  end

  uart_tx_unit #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_uart (
    .clk       (clk),
    .resetn    (resetn),
    .push      (uart_push),
    .push_data (bus.data_out[7:0]),
    .tx        (uart_tx),
    .full      (u_full),
    .empty     (u_empty),
    .busy      (u_busy),
    .overflow  (u_ovf),
    .clr_ovf   (clr_ovf)
  );

  assign halt      = halt_q;
  assign exit_code = exit_code_q;

endmodule

// File: tb/tb_core_bus_bridge.sv
// Self-checking bench for core_bus_bridge: a transaction-level model
// (queue FIFO, frame timeline, associative RAM) checked every cycle, plus
// directed sequences with hand-computed literal expectations.
module tb_core_bus_bridge;
  import bus_map_pkg::*;

  localparam int          MEMW      = 256;
  localparam int          CPB       = 4;
  localparam int          DEPTH     = 8;
  localparam logic [31:0] MEM_BYTES = 32'(MEMW * 4);

  logic       clk;
  logic       resetn;
  logic       uart_tx;
  logic       halt;
  logic [7:0] exit_code;

  core_bus_bridge_if bus ();

  core_bus_bridge #(
    .MEM_WORDS    (MEMW),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .uart_tx   (uart_tx),
    .halt      (halt),
    .exit_code (exit_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          model_valid = 1'b0;
  logic [7:0]  m_q[$];
  bit          m_active;
  logic [7:0]  m_byte;
  int          m_elapsed;
  bit          m_ovf;
  logic [31:0] m_timer;
  bit          m_halt;
  logic [7:0]  m_exit;
  logic [31:0] m_mem [int];

  // A frame is 10 bit slots of CPB cycles: start(0), 8 data LSB first, stop(1).
  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_elapsed / CPB;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  function automatic logic [31:0] exp_stat();
    return {28'b0, m_ovf, m_active, (m_q.size() == 0), (m_q.size() == DEPTH)};
  endfunction

  always @(posedge clk) begin : model_step
    logic [31:0] a, d;
    logic        w;
    int          pre_size;
    bit          popped;
    a = bus.address;
    d = bus.data_out;
    w = bus.we;
    if (!resetn) begin
      m_q.delete();
      m_active    = 1'b0;
      m_elapsed   = 0;
      m_ovf       = 1'b0;
      m_timer     = '0;
      m_halt      = 1'b0;
      m_exit      = '0;
      model_valid = 1'b1;
    end else begin
      pre_size = m_q.size();
      popped   = 1'b0;
      if (m_active) begin
        m_elapsed++;
        if (m_elapsed == 10 * CPB) m_active = 1'b0;
      end else if (pre_size > 0) begin
        m_byte    = m_q.pop_front();
        m_active  = 1'b1;
        m_elapsed = 0;
        popped    = 1'b1;
      end
      if (w) begin
        if (a < MEM_BYTES) begin
          m_mem[int'(a >> 2)] = d;
        end else if (a == UART_DATA_ADDR) begin
          if (pre_size < DEPTH || popped) m_q.push_back(d[7:0]);
          else m_ovf = 1'b1;
        end else if (a == UART_STAT_ADDR) begin
          if (d[3]) m_ovf = 1'b0;
        end else if (a == HALT_ADDR) begin
          if (!m_halt) begin
            m_halt = 1'b1;
            m_exit = d[7:0];
          end
        end
      end
      m_timer = (w && a == TIMER_ADDR) ? d : m_timer + 32'd1;
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] a;
    a = bus.address;
    if (model_valid) begin
      check("uart_tx", 32'(uart_tx), 32'(exp_tx()));
      check("halt", 32'(halt), 32'(m_halt));
      check("exit_code", 32'(exit_code), 32'(m_exit));
      if (a < MEM_BYTES) begin
        if (m_mem.exists(int'(a >> 2))) check("ram_read", bus.data_in, m_mem[int'(a >> 2)]);
      end else if (a == UART_DATA_ADDR) begin
        check("uart_data_read", bus.data_in, 32'h0);
      end else if (a == UART_STAT_ADDR) begin
        check("stat_read", bus.data_in, exp_stat());
      end else if (a == TIMER_ADDR) begin
        check("timer_read", bus.data_in, m_timer);
      end else if (a != HALT_ADDR) begin
        check("unmapped_read", bus.data_in, 32'h0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // All helpers start and end 1 time unit after a rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.address  = a;
    bus.data_out = d;
    bus.we       = 1'b1;
    @(posedge clk); #1;
    bus.we = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.address = a;
    bus.we      = 1'b0;
    @(negedge clk);
    check(name, bus.data_in, exp);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.we = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [9:0]  frame_55;
    logic [31:0] exp_bit;
    int          r;

    resetn       = 1'b0;
    bus.address  = '0;
    bus.data_out = '0;
    bus.we       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reset state
    bus.address = 32'h1000_0008;
    @(negedge clk);
    check("rst_timer", bus.data_in, 32'h0);
    check("rst_tx", 32'(uart_tx), 32'h1);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_exit", 32'(exit_code), 32'h0);
    @(posedge clk); #1;
    read_check("rst_stat", 32'h1000_0004, 32'h2);

    // RAM write then byte-offset read of the same word; unmapped read
    bus_write(32'h0000_0010, 32'hDEAD_BEEF);
    read_check("ram_offset3", 32'h0000_0013, 32'hDEAD_BEEF);
    read_check("unmapped", 32'h2000_0000, 32'h0);

    // Timer load and wrap
    bus_write(32'h1000_0008, 32'hFFFF_FFFE);
    read_check("timer_load", 32'h1000_0008, 32'hFFFF_FFFE);
    read_check("timer_max", 32'h1000_0008, 32'hFFFF_FFFF);
    read_check("timer_wrap", 32'h1000_0008, 32'h0000_0000);

    // Single byte 0x55: one idle pop cycle, then start, 8 data LSB first, stop.
    frame_55 = 10'b1_0101_0101_0;
    bus_write(32'h1000_0000, 32'h55);
    bus.address = 32'h1000_0004;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      exp_bit = (i == 0 || i > 40) ? 32'h1 : 32'(frame_55[(i - 1) / 4]);
      check("tx_0x55", 32'(uart_tx), exp_bit);
      // Mid-frame the only byte is already popped: busy and empty together.
      if (i == 20) check("stat_mid_frame", bus.data_in, 32'h6);
      if (i == 44) check("stat_after_frame", bus.data_in, 32'h2);
      @(posedge clk); #1;
    end

    // Nine back-to-back writes: first popped, eight queued -> busy|full.
    for (int i = 0; i < 9; i++) bus_write(32'h1000_0000, 32'h30 + 32'(i));
    read_check("stat_full", 32'h1000_0004, 32'h5);
    bus_write(32'h1000_0000, 32'h99);
    read_check("stat_overflow", 32'h1000_0004, 32'hD);
    bus_write(32'h1000_0004, 32'h8);
    read_check("stat_ovf_clear", 32'h1000_0004, 32'h5);
    idle(400);
    read_check("stat_drained", 32'h1000_0004, 32'h2);

    // Randomized traffic, including rare resets mid-frame.
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      bus.address = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      else if (r < 45) bus.address = MEM_BYTES - 32'd4 + 32'($urandom_range(0, 3));
      else if (r < 48) bus.address = MEM_BYTES + 32'($urandom_range(0, 3));
      else if (r < 60) bus.address = 32'h1000_0000;
      else if (r < 72) bus.address = 32'h1000_0004;
      else if (r < 82) bus.address = 32'h1000_0008;
      else if (r < 84) bus.address = 32'h1000_000C;
      else             bus.address = $urandom;
      bus.we       = 1'($urandom_range(0, 1));
      bus.data_out = $urandom;
      resetn       = ($urandom_range(0, 499) != 0);
      @(posedge clk); #1;
    end
    resetn = 1'b1;
    bus.we = 1'b0;

    // Halt: sticky, first code wins; RAM and timer keep working; reset clears.
    pulse_reset();
    bus_write(32'h1000_000C, 32'h2A);
    @(negedge clk);
    check("halt_set", 32'(halt), 32'h1);
    check("exit_code_set", 32'(exit_code), 32'h2A);
    @(posedge clk); #1;
    bus_write(32'h1000_000C, 32'h01);
    @(negedge clk);
    check("exit_code_sticky", 32'(exit_code), 32'h2A);
    @(posedge clk); #1;
    bus_write(32'h0000_0080, 32'hCAFE_F00D);
    read_check("ram_after_halt", 32'h0000_0080, 32'hCAFE_F00D);
    bus_write(32'h1000_0008, 32'h0000_0100);
    read_check("timer_after_halt", 32'h1000_0008, 32'h0000_0100);
    pulse_reset();
    @(negedge clk);
    check("halt_cleared", 32'(halt), 32'h0);
    check("exit_cleared", 32'(exit_code), 32'h0);
    @(posedge clk); #1;

    // Reset during DATA aborts the frame; a write during reset is ignored.
    bus_write(32'h0000_0040, 32'h1234_5678);
    bus_write(32'h1000_0000, 32'hA5);
    idle(12);
    resetn       = 1'b0;
    bus.address  = 32'h0000_0040;
    bus.data_out = 32'hFFFF_FFFF;
    bus.we       = 1'b1;
    @(posedge clk); #1;
    resetn      = 1'b1;
    bus.we      = 1'b0;
    bus.address = 32'h1000_0004;
    @(negedge clk);
    check("abort_tx_high", 32'(uart_tx), 32'h1);
    check("abort_stat", bus.data_in, 32'h2);
    @(posedge clk); #1;
    read_check("ram_survives_reset", 32'h0000_0040, 32'h1234_5678);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
